nf10_identifier_v2: RTL



---
 rtl/nf10_identifier_pkg.sv | 26 ++
 rtl/nf10_uptime_counter.sv | 38 +++
 rtl/nf10_identifier_v2.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/nf10_identifier_pkg.sv
// nf10_identifier_pkg: shared constants and types for the nf10 identifier block.
//   - Register offsets within the 4 KiB window (byte addresses, ADDR[11:0]).
//   - AXI response codes.
//   - Write/read channel FSM state types.
package nf10_identifier_pkg;

  localparam logic [11:0] ID_BASE      = 12'h000;
  localparam logic [11:0] UPTIME_LO    = 12'h100;
  localparam logic [11:0] UPTIME_HI    = 12'h104;
  localparam logic [11:0] CTRL         = 12'h108;
  localparam logic [11:0] INFO         = 12'h10C;
  localparam logic [11:0] SCRATCH_BASE = 12'h200;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  // Word address (ADDR[11:2]); the two byte-lane bits are ignored.
  function automatic logic [9:0] word_of(input logic [11:0] a);
    return a[11:2];
  endfunction

endpackage

// File: rtl/nf10_uptime_counter.sv
// nf10_uptime_counter: free-running 64-bit cycle counter with snapshot latch.
//   clk, rst     : clock, asynchronous active-high reset
//   clear        : zero the counter (wins over preset and increment)
//   preset       : load preset_val (debug hook, tied off in normal use)
//   preset_val   : value loaded by preset
//   snap         : capture the upper 32 bits into snap_hi this cycle
//   count_lo     : live lower 32 bits of the counter
//   snap_hi      : upper 32 bits captured at the last snap
module nf10_uptime_counter (
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        preset,
  input  logic [63:0] preset_val,
  input  logic        snap,
  output logic [31:0] count_lo,
  output logic [31:0] snap_hi
);

  logic [63:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      snap_hi <= '0;
    end else begin
      if (clear)       count <= '0;
      else if (preset) count <= preset_val;
      else             count <= count + 64'd1;
      // Captured from the same pre-update value whose low half is being read,
      // so a LO-then-HI read pair never tears across a carry.
      if (snap)        snap_hi <= count[63:32];
    end
  end

  assign count_lo = count[31:0];

endmodule

// File: rtl/nf10_identifier_v2.sv
// nf10_identifier_v2: AXI4-Lite slave exposing identification words, a 64-bit
// uptime counter with atomic LO/HI snapshot, byte-writable scratch registers,
// and SLVERR/DECERR responses for illegal accesses.
//   S_AXI_ACLK / S_AXI_ARESET : clock, asynchronous active-high reset
//   S_AXI_AW* / S_AXI_W*      : write address / data channels (independent)
//   S_AXI_B*                  : write response channel
//   S_AXI_AR* / S_AXI_R*      : read address / data channels (latency 1)
// Word 0 of C_ID_VALUE sits in the least significant 32 bits.
module nf10_identifier_v2
  import nf10_identifier_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter int C_NUM_ID_WORDS     = 4,
  parameter logic [C_NUM_ID_WORDS*32-1:0] C_ID_VALUE =
    {32'h0000_0000, 32'h0000_0000, 32'h0001_0000, 32'h4E46_3130},
  parameter int C_NUM_SCRATCH      = 2,
  parameter logic [31:0] C_SCRATCH_RESET = 32'h0
) (
  input  logic                            S_AXI_ACLK,
  input  logic                            S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int SCR_N = (C_NUM_SCRATCH > 0) ? C_NUM_SCRATCH : 1;

  logic clk, rst;
  assign clk = S_AXI_ACLK;
  assign rst = S_AXI_ARESET;

  // Debug hook for presetting the uptime counter; tied off in the design.
  wire        uptime_preset     = 1'b0;
  wire [63:0] uptime_preset_val = 64'h0;

  w_state_t    w_state;
  r_state_t    r_state;
  logic [9:0]  aw_addr_q;
  logic [31:0] w_data_q;
  logic [3:0]  w_strb_q;
  logic [31:0] scratch [SCR_N];
  logic        clear_req;
  logic [31:0] count_lo, snap_hi;

  logic        aw_hs, w_hs, ar_hs, do_write, snap;
  logic [9:0]  wa, ra;
  logic [31:0] wd, rd_val;
  logic [3:0]  ws;
  logic [1:0]  rd_resp;

  logic unused_bits;
  assign unused_bits = ^{S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:12], S_AXI_AWADDR[1:0],
                         S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:12], S_AXI_ARADDR[1:0]};

  function automatic logic [1:0] wr_resp(input logic [9:0] a);
    if (a == word_of(CTRL))
      return RESP_OKAY;
    if (a[9:6] == SCRATCH_BASE[11:8] && int'(a[5:0]) < C_NUM_SCRATCH)
      return RESP_OKAY;
    if ((a[9:6] == ID_BASE[11:8] && int'(a[5:0]) < C_NUM_ID_WORDS) ||
        a == word_of(UPTIME_LO) || a == word_of(UPTIME_HI) || a == word_of(INFO))
      return RESP_SLVERR;
    return RESP_DECERR;
  endfunction

  // An address or data beat counts as present if it is handshaking now or
  // was latched earlier (its READY is already low).
  always_comb begin
    aw_hs    = S_AXI_AWVALID && S_AXI_AWREADY;
    w_hs     = S_AXI_WVALID && S_AXI_WREADY;
    ar_hs    = S_AXI_ARVALID && S_AXI_ARREADY;
    do_write = (w_state == W_IDLE) && (aw_hs || !S_AXI_AWREADY) && (w_hs || !S_AXI_WREADY);
    wa       = aw_hs ? S_AXI_AWADDR[11:2] : aw_addr_q;
    wd       = w_hs ? S_AXI_WDATA[31:0] : w_data_q;
    ws       = w_hs ? S_AXI_WSTRB[3:0] : w_strb_q;
    ra       = S_AXI_ARADDR[11:2];
    snap     = ar_hs && (ra == word_of(UPTIME_LO));
  end

  always_comb begin
    rd_val  = '0;
    rd_resp = RESP_DECERR;
    if (ra[9:6] == ID_BASE[11:8] && int'(ra[5:0]) < C_NUM_ID_WORDS) begin
      rd_resp = RESP_OKAY;
      for (int k = 0; k < C_NUM_ID_WORDS; k++)
        if (int'(ra[5:0]) == k) rd_val = C_ID_VALUE[32*k +: 32];
    end else if (ra == word_of(UPTIME_LO)) begin
      rd_resp = RESP_OKAY;
      rd_val  = count_lo;
    end else if (ra == word_of(UPTIME_HI)) begin
      rd_resp = RESP_OKAY;
      rd_val  = snap_hi;
    end else if (ra == word_of(CTRL)) begin
      rd_resp = RESP_OKAY;
    end else if (ra == word_of(INFO)) begin
      rd_resp = RESP_OKAY;
      rd_val  = {8'h02, 8'h00, 8'(C_NUM_SCRATCH), 8'(C_NUM_ID_WORDS)};
    end else if (ra[9:6] == SCRATCH_BASE[11:8] && int'(ra[5:0]) < C_NUM_SCRATCH) begin
      rd_resp = RESP_OKAY;
      for (int k = 0; k < C_NUM_SCRATCH; k++)
        if (int'(ra[5:0]) == k) rd_val = scratch[k];
    end
  end

  nf10_uptime_counter u_uptime (
    .clk        (clk),
    .rst        (rst),
    .clear      (clear_req),
    .preset     (uptime_preset),
    .preset_val (uptime_preset_val),
    .snap       (snap),
    .count_lo   (count_lo),
    .snap_hi    (snap_hi)
  );

  // ---- write channel: capture AW/W beats ----
  always_ff @(posedge clk) begin
    if (aw_hs) aw_addr_q <= S_AXI_AWADDR[11:2];
    if (w_hs) begin
      w_data_q <= S_AXI_WDATA[31:0];
      w_strb_q <= S_AXI_WSTRB[3:0];
    end
  end

  // ---- write channel: FSM and response ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b1;
      S_AXI_WREADY  <= 1'b1;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BRESP   <= RESP_OKAY;
      clear_req     <= 1'b0;
    end else begin
      clear_req <= 1'b0;
      case (w_state)
        W_IDLE: begin
          if (aw_hs) S_AXI_AWREADY <= 1'b0;
          if (w_hs)  S_AXI_WREADY  <= 1'b0;
          if (do_write) begin
            S_AXI_AWREADY <= 1'b0;
            S_AXI_WREADY  <= 1'b0;
            S_AXI_BVALID  <= 1'b1;
            S_AXI_BRESP   <= wr_resp(wa);
            clear_req     <= (wa == word_of(CTRL)) && ws[0] && wd[0];
            w_state       <= W_RESP;
          end
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // ---- scratch registers: byte-lane writes ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < SCR_N; k++) scratch[k] <= C_SCRATCH_RESET;
    end else if (do_write && wa[9:6] == SCRATCH_BASE[11:8]) begin
      for (int k = 0; k < C_NUM_SCRATCH; k++)
        if (int'(wa[5:0]) == k)
          for (int b = 0; b < 4; b++)
            if (ws[b]) scratch[k][8*b +: 8] <= wd[8*b +: 8];
    end
  end

  // ---- read channel: registered data, latency 1 ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b1;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RRESP   <= RESP_OKAY;
      S_AXI_RDATA   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            S_AXI_ARREADY <= 1'b0;
            S_AXI_RVALID  <= 1'b1;
            S_AXI_RDATA   <= C_S_AXI_DATA_WIDTH'(rd_val);
            S_AXI_RRESP   <= rd_resp;
            r_state       <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
